// File: rtl/scan_pkg.sv
// Shared types and helpers for the LED panel scan scheduler.
package scan_pkg;

  localparam int unsigned ON_TICKS_WIDTH = 24;
  localparam int unsigned PROD_WIDTH     = ON_TICKS_WIDTH + 10;

  typedef enum logic [2:0] {
    ST_START,
    ST_SHIFT,
    ST_BLANK,
    ST_LATCH,
    ST_ON
  } scan_state_e;

  // on_ticks = ((base << plane) * (bright + 1)) >> 8
  function automatic logic [ON_TICKS_WIDTH-1:0] calc_on_ticks(
    input logic [2:0]  plane,
    input int unsigned base_ticks,
    input logic [7:0]  bright
  );
    logic [PROD_WIDTH-1:0] prod;
    prod = (PROD_WIDTH'(base_ticks) << plane) * (PROD_WIDTH'(bright) + PROD_WIDTH'(1));
    return ON_TICKS_WIDTH'(prod >> 8);
  endfunction

endpackage

// File: rtl/scan_on_timer.sv
// Loadable down-counter timing the BCM on-period; expired_o is a registered flag.
module scan_on_timer
  import scan_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      load_i,
  input  logic [ON_TICKS_WIDTH-1:0] load_val_i,
  output logic                      expired_o
);

  logic [ON_TICKS_WIDTH-1:0] count_q, count_d;
  logic                      expired_q;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - ON_TICKS_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q   <= '0;
      expired_q <= 1'b1;
    end else begin
      count_q   <= count_d;
      expired_q <= (count_d == '0);
    end
  end

  assign expired_o = expired_q;

endmodule

// File: rtl/scan_scheduler.sv
// Row/bit-plane scan sequencer for one LED panel chain.
// Define SCAN_OVERLAP_EN to shift step k+1 during the on-time of step k.
module scan_scheduler
  import scan_pkg::*;
#(
  parameter int unsigned ROW_ADDR_WIDTH = 3,
  parameter int unsigned PLANES         = 8,
  parameter int unsigned BASE_TICKS     = 8,
  parameter int unsigned BLANK_CYCLES   = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [7:0]                global_bright,
  output logic                      shift_start,
  output logic [2:0]                shift_plane,
  output logic [ROW_ADDR_WIDTH-1:0] shift_row,
  input  logic                      shift_done,
  output logic                      frame_start,
  output logic                      latch_out,
  output logic                      enable_out,
  output logic [ROW_ADDR_WIDTH-1:0] addr_out
);

  localparam int unsigned BLANK_W    = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [2:0]  LAST_PLANE = 3'(PLANES - 1);

  scan_state_e               state_q, state_d;
  logic [BLANK_W-1:0]        blank_cnt_q, blank_cnt_d;
  logic                      done_seen_q, done_seen_d;
  logic [2:0]                plane_q, plane_d;
  logic [ROW_ADDR_WIDTH-1:0] row_q, row_d;
  logic [ROW_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                      shift_start_q, shift_start_d;
  logic                      frame_start_q, frame_start_d;
  logic                      latch_q, latch_d;

  logic                      timer_load, timer_expired;
  logic                      done_now, shift_go, advance, step_wrap;
  logic [ON_TICKS_WIDTH-1:0] on_ticks;

  assign on_ticks  = calc_on_ticks(plane_q, BASE_TICKS, global_bright);
  // A done pulse in the deciding cycle counts immediately, not one cycle later.
  assign done_now  = done_seen_q | (shift_done & ((state_q == ST_SHIFT) | (state_q == ST_ON)));
  assign step_wrap = (plane_q == LAST_PLANE) && (row_q == '1);

`ifdef SCAN_OVERLAP_EN
  assign shift_go = done_now & timer_expired;
`else
  assign shift_go = done_now;
`endif

  always_comb begin
    state_d       = state_q;
    blank_cnt_d   = blank_cnt_q;
    plane_d       = plane_q;
    row_d         = row_q;
    addr_d        = addr_q;
    shift_start_d = 1'b0;
    frame_start_d = 1'b0;
    latch_d       = 1'b0;
    timer_load    = 1'b0;
    advance       = 1'b0;

    case (state_q)
      ST_START: begin
        shift_start_d = 1'b1;
        frame_start_d = 1'b1;
        state_d       = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (shift_go) begin
          state_d     = ST_BLANK;
          blank_cnt_d = '0;
        end
      end
      ST_BLANK: begin
        if (blank_cnt_q == BLANK_W'(BLANK_CYCLES - 1)) begin
          state_d = ST_LATCH;
          latch_d = 1'b1;
          addr_d  = row_q;
        end else begin
          blank_cnt_d = blank_cnt_q + BLANK_W'(1);
        end
      end
      ST_LATCH: begin
        timer_load = 1'b1;
        state_d    = ST_ON;
`ifdef SCAN_OVERLAP_EN
        advance    = 1'b1;
`endif
      end
      ST_ON: begin
`ifdef SCAN_OVERLAP_EN
        state_d = ST_SHIFT;
`else
        if (timer_expired) begin
          state_d = ST_SHIFT;
          advance = 1'b1;
        end
`endif
      end
      default: state_d = ST_START;
    endcase

    if (advance) begin
      shift_start_d = 1'b1;
      frame_start_d = step_wrap;
      if (plane_q == LAST_PLANE) begin
        plane_d = '0;
        row_d   = row_q + ROW_ADDR_WIDTH'(1);
      end else begin
        plane_d = plane_q + 3'd1;
      end
    end

    done_seen_d = shift_start_d ? 1'b0 : done_now;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_START;
      blank_cnt_q   <= '0;
      done_seen_q   <= 1'b0;
      plane_q       <= '0;
      row_q         <= '0;
      addr_q        <= '0;
      shift_start_q <= 1'b0;
      frame_start_q <= 1'b0;
      latch_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      blank_cnt_q   <= blank_cnt_d;
      done_seen_q   <= done_seen_d;
      plane_q       <= plane_d;
      row_q         <= row_d;
      addr_q        <= addr_d;
      shift_start_q <= shift_start_d;
      frame_start_q <= frame_start_d;
      latch_q       <= latch_d;
    end
  end

  // LEDs are lit only while the on-timer is counting.
  scan_on_timer u_on_timer (
    .clk_i      (clk),
    .reset_i    (reset),
    .load_i     (timer_load),
    .load_val_i (on_ticks),
    .expired_o  (timer_expired)
  );

  assign shift_start = shift_start_q;
  assign shift_plane = plane_q;
  assign shift_row   = row_q;
  assign frame_start = frame_start_q;
  assign latch_out   = latch_q;
  assign enable_out  = timer_expired;
  assign addr_out    = addr_q;

endmodule

// File: tb/tb_scan_scheduler.sv
// Self-checking bench for scan_scheduler against a step-schedule reference model.
module tb_scan_scheduler;

  localparam int ROWS  = 8;
  localparam int NPL   = 8;
  localparam int BASE  = 8;
  localparam int BLANK = 2;
  localparam int FRAME = ROWS * NPL;
  localparam int MAXS  = 80;
`ifdef SCAN_OVERLAP_EN
  localparam bit OVL = 1'b1;
`else
  localparam bit OVL = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       shift_done = 1'b0;
  logic [7:0] global_bright = 8'd0;
  logic       shift_start, frame_start, latch_out, enable_out;
  logic [2:0] shift_plane, shift_row, addr_out;

  scan_scheduler #(
    .ROW_ADDR_WIDTH (3),
    .PLANES         (8),
    .BASE_TICKS     (8),
    .BLANK_CYCLES   (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .global_bright (global_bright),
    .shift_start   (shift_start),
    .shift_plane   (shift_plane),
    .shift_row     (shift_row),
    .shift_done    (shift_done),
    .frame_start   (frame_start),
    .latch_out     (latch_out),
    .enable_out    (enable_out),
    .addr_out      (addr_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Per-step schedule (cycle numbers counted from the first cycle after reset release)
  int s_t[MAXS], d_t[MAXS], l_t[MAXS], t_on[MAXS], dly[MAXS], brt[MAXS];
  int obs_low[MAXS], obs_latch[MAXS];
  int fs_count, fs_last;

  function automatic int ref_on_ticks(input int plane, input int bright);
    return (BASE * (1 << plane) * (bright + 1)) / 256;
  endfunction

  task automatic build_plan(input int n);
    int e_prev, s, n_c;
    e_prev = -1;
    s      = 0;
    for (int k = 0; k < n; k++) begin
      s_t[k] = s;
      d_t[k] = s + dly[k];
      n_c    = d_t[k];
      if (OVL && e_prev > n_c) n_c = e_prev;
      l_t[k]  = n_c + BLANK + 1;
      t_on[k] = ref_on_ticks(k % NPL, brt[k]);
      e_prev  = l_t[k] + 1 + t_on[k];
      s       = OVL ? l_t[k] + 1 : e_prev + 1;
      obs_low[k]   = 0;
      obs_latch[k] = 0;
    end
  endtask

  task automatic start_run();
    reset      = 1'b1;
    shift_done = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  // Drives and checks cycles 0..end; returns at the drive point after the last cycle.
  task automatic run_plan(input int n, input int stop_at);
    int ks, kl, kd, end_c, err0;
    logic [12:0] got, exp_v;
    logic st, lt, en;
    logic [2:0] pl, rw, ad;
    build_plan(n + 1);
    ks = 0; kl = -1; kd = 0; fs_count = 0; fs_last = -1; err0 = errors;
    end_c = (stop_at >= 0) ? stop_at - 1 : l_t[n-1] + t_on[n-1] + 1;
    for (int c = 0; c <= end_c; c++) begin
      while (ks + 1 <= n && s_t[ks+1] <= c) ks++;
      while (kl + 1 <= n && l_t[kl+1] <= c) kl++;
      while (kd < n && d_t[kd] < c) kd++;
      shift_done    = (d_t[kd] == c);
      global_bright = 8'(brt[ks]);
      st = (s_t[ks] == c);
      pl = 3'(ks % NPL);
      rw = 3'((ks / NPL) % ROWS);
      lt = (kl >= 0) && (l_t[kl] == c);
      en = !((kl >= 0) && (c > l_t[kl]) && (c <= l_t[kl] + t_on[kl]));
      ad = (kl >= 0) ? 3'((kl / NPL) % ROWS) : 3'd0;
      exp_v = {st, st && (ks % FRAME == 0), pl, rw, lt, en, ad};
      @(negedge clk);
      got = {shift_start, frame_start, shift_plane, shift_row, latch_out, enable_out, addr_out};
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL outputs cyc=%0d step=%0d got=%h exp=%h", c, ks, got, exp_v);
      end
      if (kl >= 0 && enable_out === 1'b0) obs_low[kl]++;
      if (kl >= 0 && latch_out === 1'b1) obs_latch[kl]++;
      if (frame_start === 1'b1) begin fs_count++; fs_last = c; end
      @(posedge clk); #1;
      if (errors - err0 > 10) break;
    end
    shift_done = 1'b0;
  endtask

  task automatic test_reset();
    logic [12:0] got;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      got = {shift_start, frame_start, shift_plane, shift_row, latch_out, enable_out, addr_out};
      checks++;
      if (got !== 13'h008) begin
        errors++;
        $display("FAIL reset_values got=%h exp=%h", got, 13'h008);
      end
    end
  endtask

  task automatic test_first_frame();
    start_run();
    for (int k = 0; k <= 9; k++) begin
      dly[k] = 416;
      brt[k] = $urandom_range(0, 255);
    end
    run_plan(9, -1);
  endtask

  task automatic test_bcm_planes();
    start_run();
    for (int k = 0; k <= 9; k++) begin
      dly[k] = $urandom_range(8, 60);
      brt[k] = $urandom_range(0, 255);
    end
    brt[0] = 0;
    brt[3] = 255;
    dly[4] = 64;    // shift of step 4 finishes exactly when step 3's on-time ends
    brt[7] = 127;
    dly[8] = 416;
    run_plan(9, -1);
    checks++;
    if (obs_low[0] !== 0) begin errors++; $display("FAIL plane0_dark got=%0d exp=%0d", obs_low[0], 0); end
    checks++;
    if (obs_latch[0] !== 1) begin errors++; $display("FAIL plane0_latch got=%0d exp=%0d", obs_latch[0], 1); end
    checks++;
    if (obs_latch[1] !== 1) begin errors++; $display("FAIL plane0_advance got=%0d exp=%0d", obs_latch[1], 1); end
    checks++;
    if (obs_low[3] !== 64) begin errors++; $display("FAIL plane3_ontime got=%0d exp=%0d", obs_low[3], 64); end
    checks++;
    if (obs_latch[3] !== 1) begin errors++; $display("FAIL plane3_latch got=%0d exp=%0d", obs_latch[3], 1); end
    checks++;
    if (obs_low[7] !== 512) begin errors++; $display("FAIL plane7_ontime got=%0d exp=%0d", obs_low[7], 512); end
  endtask

  task automatic test_full_frame();
    start_run();
    for (int k = 0; k <= 65; k++) begin
      dly[k] = $urandom_range(8, 40);
      brt[k] = $urandom_range(0, 255);
    end
    run_plan(65, -1);
    checks++;
    if (fs_count !== 2) begin errors++; $display("FAIL frame_start_count got=%0d exp=%0d", fs_count, 2); end
    checks++;
    if (fs_last !== s_t[64]) begin errors++; $display("FAIL frame_start_step64 got=%0d exp=%0d", fs_last, s_t[64]); end
  endtask

  task automatic test_reset_mid_on();
    int stop;
    logic [12:0] got;
    start_run();
    for (int k = 0; k <= 8; k++) begin
      dly[k] = $urandom_range(8, 60);
      brt[k] = $urandom_range(0, 255);
    end
    brt[7] = 255;
    build_plan(9);
    stop = l_t[7] + 300;
    run_plan(8, stop);
    reset      = 1'b1;
    shift_done = 1'b0;
    @(negedge clk);
    checks++;
    if (enable_out !== 1'b0) begin errors++; $display("FAIL mid_on_lit got=%b exp=%b", enable_out, 1'b0); end
    @(posedge clk); #1;
    @(negedge clk);
    got = {shift_start, frame_start, shift_plane, shift_row, latch_out, enable_out, addr_out};
    checks++;
    if (got !== 13'h008) begin errors++; $display("FAIL reset_mid_on got=%h exp=%h", got, 13'h008); end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k <= 3; k++) begin
      dly[k] = 416;
      brt[k] = $urandom_range(0, 255);
    end
    run_plan(3, -1);
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_bcm_planes();
    test_full_frame();
    test_reset_mid_on();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/scan_scheduler.md
# scan_scheduler

Sequences one LED matrix panel chain: chooses the row and bit-plane to shift, handshakes with the pixel shifter, blanks, latches, selects the row address and times the binary-coded-modulation on-period. Sits between the framebuffer-reading pixel shifter and the physical latch/!enable/address pins, so the shifter only serialises pixels. One instance drives both data chains, since they share latch, enable and address.

## Interface
- `ROW_ADDR_WIDTH`, 3 — display address lines; rows = 2^ROW_ADDR_WIDTH.
- `PLANES`, 8 — bit-planes per row, LSB first; max 8.
- `BASE_TICKS`, 8 — clk cycles of on-time for plane 0 at full brightness.
- `BLANK_CYCLES`, 2 — cycles enable is deasserted before latch; min 1.

Ports:
- `clk`  in  1  — display clock; single clock domain.
- `reset`  in  1  — synchronous, active-high.
- `global_bright`  in  8  — brightness scale; sampled on the latch cycle.
- `shift_start`  out  1  — one-cycle pulse; shifter begins a row of pixels.
- `shift_plane`  out  3  — plane to shift; held from `shift_start` until the next `shift_start`.
- `shift_row`  out  ROW_ADDR_WIDTH  — row to shift; held like `shift_plane`.
- `shift_done`  in  1  — one-cycle pulse from shifter; row fully clocked out.
- `frame_start`  out  1  — pulse coincident with `shift_start` for row 0, plane 0; shifter rewinds framebuffer read address.
- `latch_out`  out  1  — panel latch; high exactly one cycle per step.
- `enable_out`  out  1  — panel !enable; 1 = LEDs off.
- `addr_out`  out  ROW_ADDR_WIDTH  — panel row select.

## Operation
- Step order: (row 0, plane 0 … PLANES-1), then row 1, …; after (last row, last plane), wrap to (0,0) and pulse `frame_start`.
- States: START, SHIFT, BLANK, LATCH, ON.
- START: entered after reset. Issues `shift_start` for (0,0) with `frame_start`, then goes to SHIFT.
- SHIFT: waits for `done_seen` AND `timer_expired`, then goes to BLANK.
- `done_seen`: sticky flag. Set by `shift_done`. Cleared on `shift_start`.
- `shift_done` outside SHIFT/ON with no shift outstanding: ignored.
- BLANK: `enable_out`=1 for BLANK_CYCLES cycles, then LATCH.
- LATCH: `latch_out`=1 and `addr_out`=`shift_row` of the shifted step, both in the same cycle. Computes `on_ticks` = ((BASE_TICKS << plane) * (global_bright + 1)) >> 8. Arithmetic is unsigned, 24 bits, no overflow at max parameters.
- ON: loads the timer with `on_ticks`; `enable_out`=0 while timer > 0. If `on_ticks`=0, `enable_out` stays 1 and the timer is expired immediately. In the first ON cycle, advance the step and issue `shift_start` for it (overlap), then return to SHIFT.
- Simultaneous `shift_done` and timer expiry: both counted in the same cycle; no extra wait.
- Reset mid-operation: all state returns to reset values next cycle. Outstanding shifter activity is abandoned. The shifter restarts on `frame_start`.

## Timing
- Reset values: `shift_start`=0, `shift_plane`=0, `shift_row`=0, `frame_start`=0, `latch_out`=0, `enable_out`=1, `addr_out`=0. Timer expired, `done_seen`=0.
- First `shift_start` occurs in the cycle after `reset` deasserts.
- Condition met at cycle N → `enable_out`=1 from N+1 through N+BLANK_CYCLES. `latch_out`=1 at N+BLANK_CYCLES+1. `enable_out`=0 from N+BLANK_CYCLES+2 for `on_ticks` cycles. `shift_start` for the next step at N+BLANK_CYCLES+2.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- `SCAN_OVERLAP_EN` defined: shift of step k+1 overlaps the on-time of step k, as described above.
- `SCAN_OVERLAP_EN` undefined: `shift_start` for step k+1 is issued in the cycle after the ON timer expires. SHIFT then waits on `done_seen` only. Lower refresh rate; simpler for bring-up.

## Structure
- Package `scan_pkg`:
  - state enum
  - `ON_TICKS_WIDTH`=24
  - function computing `on_ticks` from plane, BASE_TICKS and brightness
- Sub-module `scan_on_timer`: loadable 24-bit down-counter with `expired` flag, instantiated once.

## Test plan
- Reset released, shifter model returns `shift_done` 416 cycles after `shift_start` → first `shift_start` with `frame_start`=1, row 0, plane 0; `enable_out`=1 until first ON.
- Plane 3, `global_bright`=255 → `latch_out` one cycle, then `enable_out`=0 for exactly 64 cycles.
- Plane 0, `global_bright`=0 → `on_ticks`=0; `enable_out` never 0 for that step; sequence still advances.
- Plane 7, `global_bright`=127, shifter 416 cycles → on-time 512 cycles; `done_seen` held pending; BLANK starts the cycle after timer expiry.
- Run 64 steps at ROW_ADDR_WIDTH=3, PLANES=8 → `addr_out` 0…7 then wraps to 0; second `frame_start` pulses exactly at step 64.
- `reset` asserted during ON → next cycle `enable_out`=1, `latch_out`=0, `addr_out`=0; restart matches the first scenario.
